// File: rtl/adsr_voice_sequencer.sv
// adsr_voice_sequencer
// Holds the envelope context of every voice (ADSR state, volume, pending
// note-on/off flags, MIDI channel). A sample tick launches a sweep that
// visits one voice per clock. Each visited context goes to an external
// combinational ADSR stage. The stage's result is written back and
// streamed to the mixer as a registered envelope pulse.
// Note events from the voice allocator are always accepted. An event that
// lands on the voice being written back wins over that voice's flag clear,
// so the note is seen on the following sweep.
// Optional feature: define ADSR_MONITOR_EN to add o_active_count. This
// output gives the number of non-BLANK voices seen by the last complete
// sweep.
module adsr_voice_sequencer #(
  parameter int NB_VOICES = 16,
  parameter int VOICE_W   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_tick,
  input  logic               i_evt_valid,
  output logic               o_evt_ready,
  input  logic [VOICE_W-1:0] i_evt_voice,
  input  logic               i_evt_on,
  input  logic [3:0]         i_evt_channel,
  input  logic               i_fifo_empty,
  output logic [2:0]         o_adsr_state,
  output logic [17:0]        o_adsr_volume,
  output logic               o_adsr_pressed,
  output logic               o_adsr_released,
  output logic [3:0]         o_adsr_channel,
  output logic               o_adsr_fifo_empty,
  input  logic [2:0]         i_adsr_state,
  input  logic [17:0]        i_adsr_volume,
  output logic               o_env_valid,
  output logic [VOICE_W-1:0] o_env_voice,
  output logic [17:0]        o_env_volume,
  output logic               o_busy,
  output logic               o_overrun
`ifdef ADSR_MONITOR_EN
  ,
  output logic [VOICE_W:0]   o_active_count
`endif
);

  localparam logic [VOICE_W-1:0] LAST_IDX = VOICE_W'(NB_VOICES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fsm_t;

  fsm_t               fsm_reg;
  fsm_t               fsm_next;
  logic [VOICE_W-1:0] idx_reg;
  logic [VOICE_W-1:0] idx_next;
  logic               write_en;
  logic               overrun_next;
  logic               ready_reg;
  logic               evt_fire;

  logic               env_valid_reg;
  logic [VOICE_W-1:0] env_voice_reg;
  logic [17:0]        env_volume_reg;
  logic               overrun_reg;

  // Flattened view of all voice contexts, one slice per voice
  logic [NB_VOICES-1:0][2:0]  ctx_state;
  logic [NB_VOICES-1:0][17:0] ctx_volume;
  logic [NB_VOICES-1:0]       ctx_pressed;
  logic [NB_VOICES-1:0]       ctx_released;
  logic [NB_VOICES-1:0][3:0]  ctx_channel;

  assign evt_fire = i_evt_valid & ready_reg;

  // Sweep FSM state and voice index register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_reg <= IDLE;
      idx_reg <= '0;
    end else begin
      fsm_reg <= fsm_next;
      idx_reg <= idx_next;
    end
  end

  // Next-state logic. The index stays at 0 while idle, so the ADSR stage then sees voice 0.
  always_comb begin
    fsm_next     = fsm_reg;
    idx_next     = idx_reg;
    write_en     = 1'b0;
    overrun_next = 1'b0;
    case (fsm_reg)
      IDLE: begin
        idx_next = '0;
        if (i_tick) begin
          fsm_next = SWEEP;
        end
      end
      SWEEP: begin
        write_en     = 1'b1;
        overrun_next = i_tick;
        if (idx_reg == LAST_IDX) begin
          fsm_next = IDLE;
          idx_next = '0;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: begin
        fsm_next = IDLE;
        idx_next = '0;
      end
    endcase
  end

  // Per-voice context storage: ADSR write-back first, then note events (events take priority)
  generate
    for (genvar gi = 0; gi < NB_VOICES; gi++) begin : gen_voice
      logic [2:0]  state_reg;
      logic [17:0] volume_reg;
      logic        pressed_reg;
      logic        released_reg;
      logic [3:0]  channel_reg;
      logic        wb_hit;
      logic        evt_hit;

      assign wb_hit  = write_en && (idx_reg == VOICE_W'(gi));
      assign evt_hit = evt_fire && (i_evt_voice == VOICE_W'(gi));

      // Context update for this voice
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          state_reg    <= 3'd0;
          volume_reg   <= 18'd0;
          pressed_reg  <= 1'b0;
          released_reg <= 1'b0;
          channel_reg  <= 4'd0;
        end else begin
          if (wb_hit) begin
            state_reg    <= i_adsr_state;
            volume_reg   <= i_adsr_volume;
            pressed_reg  <= 1'b0;
            released_reg <= 1'b0;
          end
          if (evt_hit) begin
            if (i_evt_on) begin
              pressed_reg  <= 1'b1;
              released_reg <= 1'b0;
              channel_reg  <= i_evt_channel;
            end else begin
              pressed_reg  <= 1'b0;
              released_reg <= 1'b1;
            end
          end
        end
      end

      assign ctx_state[gi]    = state_reg;
      assign ctx_volume[gi]   = volume_reg;
      assign ctx_pressed[gi]  = pressed_reg;
      assign ctx_released[gi] = released_reg;
      assign ctx_channel[gi]  = channel_reg;
    end
  endgenerate

  // Event handshake: ready is held low in reset and stays high afterwards
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_reg <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
    end
  end

  // Registered envelope stream to the mixer, plus the tick-overrun pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      env_valid_reg  <= 1'b0;
      env_voice_reg  <= '0;
      env_volume_reg <= 18'd0;
      overrun_reg    <= 1'b0;
    end else begin
      env_valid_reg <= write_en;
      overrun_reg   <= overrun_next;
      if (write_en) begin
        env_voice_reg  <= idx_reg;
        env_volume_reg <= i_adsr_volume;
      end
    end
  end

`ifdef ADSR_MONITOR_EN
  logic [VOICE_W:0] acc_reg;
  logic [VOICE_W:0] count_reg;
  logic [VOICE_W:0] acc_sum;

  // Running count of active voices; restarts from zero at voice 0 of each sweep
  always_comb begin
    acc_sum = ((idx_reg == '0) ? '0 : acc_reg)
            + (VOICE_W + 1)'(i_adsr_state != 3'd0);
  end

  // Accumulate during the sweep; publish the total on the final write-back
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_reg   <= '0;
      count_reg <= '0;
    end else if (write_en) begin
      acc_reg <= acc_sum;
      if (idx_reg == LAST_IDX) begin
        count_reg <= acc_sum;
      end
    end
  end

  assign o_active_count = count_reg;
`endif

  assign o_evt_ready       = ready_reg;
  assign o_adsr_state      = ctx_state[idx_reg];
  assign o_adsr_volume     = ctx_volume[idx_reg];
  assign o_adsr_pressed    = ctx_pressed[idx_reg];
  assign o_adsr_released   = ctx_released[idx_reg];
  assign o_adsr_channel    = ctx_channel[idx_reg];
  assign o_adsr_fifo_empty = i_fifo_empty;
  assign o_env_valid       = env_valid_reg;
  assign o_env_voice       = env_voice_reg;
  assign o_env_volume      = env_volume_reg;
  assign o_busy            = (fsm_reg == SWEEP);
  assign o_overrun         = overrun_reg;

endmodule

// File: tb/tb_adsr_voice_sequencer.sv
// Directed testbench for adsr_voice_sequencer.
// The bench contains a toy ADSR stage:
// - pressed   -> ATTACK (1), volume kept;
// - released  -> RELEASE (4), volume kept;
// - ATTACK    -> volume + 5;
// - otherwise -> context unchanged.
// Define ADSR_MONITOR_EN to also check o_active_count.
module tb_adsr_voice_sequencer;
  localparam int N = 16;
  localparam logic [17:0] ATTACK_RATE = 18'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        evt_valid = 1'b0;
  logic [3:0]  evt_voice = 4'd0;
  logic        evt_on = 1'b0;
  logic [3:0]  evt_channel = 4'd0;
  logic        fifo_empty = 1'b0;
  logic        evt_ready;
  logic [2:0]  adsr_state_o;
  logic [17:0] adsr_volume_o;
  logic        adsr_pressed;
  logic        adsr_released;
  logic [3:0]  adsr_channel;
  logic        adsr_fifo_empty;
  logic [2:0]  adsr_state_i;
  logic [17:0] adsr_volume_i;
  logic        env_valid;
  logic [3:0]  env_voice;
  logic [17:0] env_volume;
  logic        busy;
  logic        overrun;
`ifdef ADSR_MONITOR_EN
  logic [4:0]  active_count;
`endif

  adsr_voice_sequencer #(.NB_VOICES(N), .VOICE_W(4)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_tick           (tick),
    .i_evt_valid      (evt_valid),
    .o_evt_ready      (evt_ready),
    .i_evt_voice      (evt_voice),
    .i_evt_on         (evt_on),
    .i_evt_channel    (evt_channel),
    .i_fifo_empty     (fifo_empty),
    .o_adsr_state     (adsr_state_o),
    .o_adsr_volume    (adsr_volume_o),
    .o_adsr_pressed   (adsr_pressed),
    .o_adsr_released  (adsr_released),
    .o_adsr_channel   (adsr_channel),
    .o_adsr_fifo_empty(adsr_fifo_empty),
    .i_adsr_state     (adsr_state_i),
    .i_adsr_volume    (adsr_volume_i),
    .o_env_valid      (env_valid),
    .o_env_voice      (env_voice),
    .o_env_volume     (env_volume),
    .o_busy           (busy),
    .o_overrun        (overrun)
`ifdef ADSR_MONITOR_EN
    ,
    .o_active_count   (active_count)
`endif
  );

  always #5 clk = ~clk;

  // Toy ADSR stage
  always_comb begin
    adsr_state_i  = adsr_state_o;
    adsr_volume_i = adsr_volume_o;
    if (adsr_pressed) begin
      adsr_state_i = 3'd1;
    end else if (adsr_released) begin
      adsr_state_i = 3'd4;
    end else if (adsr_state_o == 3'd1) begin
      adsr_volume_i = adsr_volume_o + ATTACK_RATE;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Per-sweep capture of what the ADSR stage saw and what the mixer got
  logic [2:0]  pres_st  [N];
  logic [17:0] pres_vol [N];
  logic        pres_p   [N];
  logic        pres_r   [N];
  logic [3:0]  pres_ch  [N];
  logic [17:0] env_vol  [N];
  int pos = 0;
  int env_cnt = 0;
  int env_bad = 0;
  int busy_cnt = 0;
  int ov_cnt = 0;

  always @(negedge clk) begin
    if (busy && pos < N) begin
      pres_st[pos]  = adsr_state_o;
      pres_vol[pos] = adsr_volume_o;
      pres_p[pos]   = adsr_pressed;
      pres_r[pos]   = adsr_released;
      pres_ch[pos]  = adsr_channel;
    end
    pos = busy ? pos + 1 : 0;
    if (env_valid) begin
      if (env_voice != env_cnt[3:0]) env_bad++;
      env_vol[env_voice] = env_volume;
      env_cnt++;
    end
    if (busy) busy_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic send_evt(input logic [3:0] v, input logic on, input logic [3:0] ch);
    @(negedge clk);
    evt_valid = 1'b1;
    evt_voice = v;
    evt_on = on;
    evt_channel = ch;
    @(negedge clk);
    evt_valid = 1'b0;
    $display("event: voice=%0d on=%0d ch=%0d", v, on, ch);
  endtask

  // One sweep.
  // tick2_at / evt_at: cycle within the sweep (1 = voice 0 presented) at
  // which to inject an extra tick or a note event; 0 means none.
  task automatic do_sweep(input string name, input int tick2_at, input int evt_at,
                          input logic [3:0] ev_v, input logic ev_on, input logic [3:0] ev_ch);
    int c;
    env_cnt = 0;
    env_bad = 0;
    busy_cnt = 0;
    ov_cnt = 0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    c = 1;
    while (busy && c < 40) begin
      tick = (c == tick2_at);
      if (c == evt_at) begin
        evt_valid = 1'b1;
        evt_voice = ev_v;
        evt_on = ev_on;
        evt_channel = ev_ch;
      end else begin
        evt_valid = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    tick = 1'b0;
    evt_valid = 1'b0;
    if (c >= 40) check({name, " timeout"}, 32'd1, 32'd0);
    repeat (2) @(negedge clk);
    $display("%s: busy_cycles=%0d pulses=%0d overruns=%0d", name, busy_cnt, env_cnt, ov_cnt);
    check({name, " busy_cycles"}, busy_cnt, 16);
    check({name, " pulses"}, env_cnt, 16);
    check({name, " voice_order_errs"}, env_bad, 0);
  endtask

  int sum_vol;
  int sum_st;
  int sum_p;

  task automatic sum_sweep();
    sum_vol = 0;
    sum_st = 0;
    sum_p = 0;
    for (int i = 0; i < N; i++) begin
      sum_vol += int'(env_vol[i]);
      sum_st += int'(pres_st[i]);
      sum_p += int'(pres_p[i]) + int'(pres_r[i]);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst evt_ready", evt_ready, 0);
    check("rst busy", busy, 0);
    check("rst env_valid", env_valid, 0);
    check("rst overrun", overrun, 0);
    check("rst adsr_state", adsr_state_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("evt_ready after rst", evt_ready, 1);
    fifo_empty = 1'b1;
    #1 check("fifo_empty passthru", adsr_fifo_empty, 1);
    fifo_empty = 1'b0;

    // S1: everything idle
    do_sweep("S1", 0, 0, 4'd0, 1'b0, 4'd0);
    sum_sweep();
    check("S1 vol sum", sum_vol, 0);
    check("S1 state sum", sum_st, 0);
    check("S1 flag sum", sum_p, 0);
    check("S1 idle state", adsr_state_o, 0);

    // S2/S3: note-on v3
    send_evt(4'd3, 1'b1, 4'd5);
    do_sweep("S2", 0, 0, 4'd0, 1'b0, 4'd0);
    check("S2 v3 pressed", pres_p[3], 1);
    check("S2 v3 channel", pres_ch[3], 5);
    check("S2 v2 pressed", pres_p[2], 0);
    check("S2 v3 env vol", env_vol[3], 0);
`ifdef ADSR_MONITOR_EN
    check("S2 active_count", active_count, 1);
`endif
    do_sweep("S3", 0, 0, 4'd0, 1'b0, 4'd0);
    check("S3 v3 state", pres_st[3], 1);
    check("S3 v3 pressed", pres_p[3], 0);
    check("S3 v3 env vol", env_vol[3], 5);

    // S4: note-on then note-off v7 before the tick
    send_evt(4'd7, 1'b1, 4'd9);
    send_evt(4'd7, 1'b0, 4'd2);
    do_sweep("S4", 0, 0, 4'd0, 1'b0, 4'd0);
    check("S4 v7 pressed", pres_p[7], 0);
    check("S4 v7 released", pres_r[7], 1);
    check("S4 v7 channel", pres_ch[7], 9);
    check("S4 v3 vol in", pres_vol[3], 5);
    check("S4 v3 env vol", env_vol[3], 10);

    // S5: note-on v4 lands on v4's write-back edge
    do_sweep("S5", 0, 5, 4'd4, 1'b1, 4'd1);
    check("S5 v7 state", pres_st[7], 4);
    check("S5 v7 released", pres_r[7], 0);
    check("S5 v4 pressed", pres_p[4], 0);

    // S6: second tick 5 cycles in
    do_sweep("S6", 5, 0, 4'd0, 1'b0, 4'd0);
    check("S6 overrun pulses", ov_cnt, 1);
    check("S6 v4 pressed kept", pres_p[4], 1);
    check("S6 v4 channel", pres_ch[4], 1);
`ifdef ADSR_MONITOR_EN
    check("S6 active_count", active_count, 3);
`endif

    // Asynchronous reset mid-sweep
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("reset mid-sweep: busy=%0d env_valid=%0d", busy, env_valid);
    check("midrst busy", busy, 0);
    check("midrst env_valid", env_valid, 0);
    check("midrst evt_ready", evt_ready, 0);
    check("midrst adsr_vol", adsr_volume_o, 0);
`ifdef ADSR_MONITOR_EN
    check("midrst active_count", active_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep("S7", 0, 0, 4'd0, 1'b0, 4'd0);
    sum_sweep();
    check("S7 vol sum", sum_vol, 0);
    check("S7 state sum", sum_st, 0);
    check("S7 flag sum", sum_p, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
